register_write_port: RTL and testbench

//  Write side of the 8 x 16-bit CPU register file: holds R0..R7 and drives them on q0..q7

---
 rtl/register_write_port.sv | 116 +++++++++++
 tb/tb_register_write_port.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/register_write_port.sv
// rtl/register_write_port.sv - queued write port and storage for the 8 x DATA_WIDTH register file
// Optional build macro: ZERO_REG_EN (R0 hardwired to zero, writes to R0 dropped at the head).
module register_write_port #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    DEPTH       = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [2:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  hold,
    output logic [DATA_WIDTH-1:0] q0,
    output logic [DATA_WIDTH-1:0] q1,
    output logic [DATA_WIDTH-1:0] q2,
    output logic [DATA_WIDTH-1:0] q3,
    output logic [DATA_WIDTH-1:0] q4,
    output logic [DATA_WIDTH-1:0] q5,
    output logic [DATA_WIDTH-1:0] q6,
    output logic [DATA_WIDTH-1:0] q7,
    output logic [7:0]            pending,
    output logic [2:0]            fifo_count
);

    localparam int         PTR_W   = (DEPTH > 2) ? 2 : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [2:0]            count;
    logic [DEPTH-1:0]      valid_q;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [2:0]            addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs   [8];

    logic push;
    logic pop;

    assign wr_ready   = (count != DEPTH_C);
    assign fifo_count = count;
    assign push       = wr_valid & wr_ready;
    assign pop        = ~hold & (count != 3'd0);

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= 3'd0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= 3'd0;
            end
            for (int r = 0; r < 8; r++) begin
                regs[r] <= RESET_VALUE;
            end
        end else begin
            // Pop clears before push sets; the two slots differ whenever both fire.
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= next_ptr(rd_ptr);
`ifdef ZERO_REG_EN
                if (addr_q[rd_ptr] != 3'd0) begin
                    regs[addr_q[rd_ptr]] <= data_q[rd_ptr];
                end
`else
                regs[addr_q[rd_ptr]] <= data_q[rd_ptr];
`endif
            end
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                data_q[wr_ptr]  <= wr_data;
                addr_q[wr_ptr]  <= wr_addr;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        pending = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                pending[addr_q[i]] = 1'b1;
            end
        end
`ifdef ZERO_REG_EN
        pending[0] = 1'b0;
`endif
    end

`ifdef ZERO_REG_EN
    assign q0 = '0;
`else
    assign q0 = regs[0];
`endif
    assign q1 = regs[1];
    assign q2 = regs[2];
    assign q3 = regs[3];
    assign q4 = regs[4];
    assign q5 = regs[5];
    assign q6 = regs[6];
    assign q7 = regs[7];

endmodule

// File: tb/tb_register_write_port.sv
// tb/tb_register_write_port.sv - directed self-checking bench for register_write_port (DEPTH=2)
module tb_register_write_port;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        hold;
    logic [15:0] q0, q1, q2, q3, q4, q5, q6, q7;
    logic [7:0]  pending;
    logic [2:0]  fifo_count;
    logic [15:0] qv [8];

    int errors = 0;
    int checks = 0;

    register_write_port #(.DATA_WIDTH(16), .DEPTH(2), .RESET_VALUE(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .hold(hold),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
        .pending(pending), .fifo_count(fifo_count)
    );

    assign qv[0] = q0;
    assign qv[1] = q1;
    assign qv[2] = q2;
    assign qv[3] = q3;
    assign qv[4] = q4;
    assign qv[5] = q5;
    assign qv[6] = q6;
    assign qv[7] = q7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 16'h0000;
        hold     = 1'b0;
        #2;
        for (int r = 0; r < 8; r++) chk($sformatf("reset_q%0d", r), 32'(qv[r]), 32'h0);
        chk("reset_count", 32'(fifo_count), 32'd0);
        chk("reset_pending", 32'(pending), 32'h00);
        chk("reset_ready", 32'(wr_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Single write, latency one edge
        wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
        tick();
        wr_valid = 1'b0;
        chk("lat_pending_after_N", 32'(pending), 32'h20);
        chk("lat_q5_after_N", 32'(q5), 32'h0);
        chk("lat_count_after_N", 32'(fifo_count), 32'd1);
        tick();
        chk("lat_q5_after_N1", 32'(q5), 32'hBEEF);
        chk("lat_pending_after_N1", 32'(pending), 32'h00);
        chk("lat_count_after_N1", 32'(fifo_count), 32'd0);

        // Fill under hold, third request held off
        hold = 1'b1;
        wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 16'h0001;
        tick();
        chk("hold_count1", 32'(fifo_count), 32'd1);
        wr_addr = 3'd2; wr_data = 16'h0002;
        tick();
        chk("hold_count2", 32'(fifo_count), 32'd2);
        chk("hold_ready0", 32'(wr_ready), 32'd0);
        chk("hold_pending", 32'(pending), 32'h06);
        wr_addr = 3'd3; wr_data = 16'h0003;
        tick();
        chk("hold_full_count", 32'(fifo_count), 32'd2);
        chk("hold_full_ready", 32'(wr_ready), 32'd0);
        chk("hold_q1_unwritten", 32'(q1), 32'h0);
        hold = 1'b0;
        tick();
        chk("drain_q1", 32'(q1), 32'h0001);
        chk("drain_q2_not_yet", 32'(q2), 32'h0);
        chk("drain_count_a", 32'(fifo_count), 32'd1);
        tick();
        wr_valid = 1'b0;
        chk("drain_q2", 32'(q2), 32'h0002);
        chk("drain_q3_not_yet", 32'(q3), 32'h0);
        chk("drain_count_b", 32'(fifo_count), 32'd1);
        tick();
        chk("drain_q3", 32'(q3), 32'h0003);
        chk("drain_count_c", 32'(fifo_count), 32'd0);
        chk("drain_pending", 32'(pending), 32'h00);

        // Back-to-back writes to one register; simultaneous push/pop at count 1
        wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 16'h1111;
        tick();
        wr_data = 16'h2222;
        tick();
        wr_valid = 1'b0;
        chk("waw_q2_first", 32'(q2), 32'h1111);
        chk("waw_pending2", 32'(pending), 32'h04);
        chk("pushpop_count", 32'(fifo_count), 32'd1);
        chk("pushpop_ready", 32'(wr_ready), 32'd1);
        tick();
        chk("waw_q2_second", 32'(q2), 32'h2222);
        chk("waw_pending_clear", 32'(pending), 32'h00);

        // Write to R0
        wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        tick();
        wr_valid = 1'b0;
`ifdef ZERO_REG_EN
        chk("r0_pending", 32'(pending), 32'h00);
`else
        chk("r0_pending", 32'(pending), 32'h01);
`endif
        chk("r0_count", 32'(fifo_count), 32'd1);
        tick();
`ifdef ZERO_REG_EN
        chk("r0_q0", 32'(q0), 32'h0000);
`else
        chk("r0_q0", 32'(q0), 32'hFFFF);
`endif
        chk("r0_count_after", 32'(fifo_count), 32'd0);

        // Reset mid-run with two entries queued
        hold = 1'b1;
        wr_valid = 1'b1; wr_addr = 3'd6; wr_data = 16'hAAAA;
        tick();
        wr_addr = 3'd7; wr_data = 16'h5555;
        tick();
        wr_valid = 1'b0;
        chk("rst_pre_count", 32'(fifo_count), 32'd2);
        rst_n = 1'b0;
        #2;
        chk("rst_async_count", 32'(fifo_count), 32'd0);
        chk("rst_async_pending", 32'(pending), 32'h00);
        chk("rst_async_ready", 32'(wr_ready), 32'd1);
        chk("rst_async_q2", 32'(q2), 32'h0);
        chk("rst_async_q5", 32'(q5), 32'h0);
        hold = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_q6_discarded", 32'(q6), 32'h0);
        chk("rst_q7_discarded", 32'(q7), 32'h0);
        chk("rst_post_count", 32'(fifo_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
